// File: rtl/lab3_vec_seq.sv
// Drives the eight 3-bit input vectors of the lab3 combinational stage, holding each
// for PERIOD cycles, and packs the {y,x} responses into a 16-bit result word.
module lab3_vec_seq #(
    parameter int PERIOD = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        x,
    input  logic        y,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        busy,
    output logic        done,
    output logic [2:0]  vec_idx,
    output logic [15:0] resp,
    output logic [1:0]  dbg_state
);

    generate
        if (PERIOD < 1 || PERIOD > 255) begin : g_bad_period
            $error("lab3_vec_seq: PERIOD must be in 1..255");
        end
    endgenerate

    localparam logic [7:0] CNT_LAST = 8'(PERIOD - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_FINISH = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [2:0]  abc_q, abc_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [15:0] resp_q, resp_d;

    // Handshake: start is a level request, looked at only in IDLE; done is a one-cycle pulse.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        abc_d   = abc_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        resp_d  = resp_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d  = 8'd0;
                idx_d  = 3'd0;
                abc_d  = 3'd0;
                busy_d = 1'b0;
                if (start) begin
                    state_d = ST_HOLD;
                    busy_d  = 1'b1;
                    resp_d  = 16'h0000;
                end
            end
            ST_HOLD: begin
                if (cnt_q == CNT_LAST) begin
                    // Last cycle of this vector's window: the stage output has settled.
                    resp_d[{idx_q, 1'b0} +: 2] = {y, x};
                    cnt_d = 8'd0;
                    if (idx_q == 3'd7) begin
                        state_d = ST_FINISH;
                        idx_d   = 3'd0;
                        abc_d   = 3'd0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 3'd1;
                        abc_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 8'd0;
                idx_d   = 3'd0;
                abc_d   = 3'd0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            idx_q   <= 3'd0;
            abc_q   <= 3'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            resp_q  <= 16'h0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            abc_q   <= abc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            resp_q  <= resp_d;
        end
    end

    assign {a, b, c} = abc_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign vec_idx   = idx_q;
    assign resp      = resp_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_lab3_vec_seq.sv
// Bench for lab3_vec_seq: one instance at PERIOD=10, one at PERIOD=1, each answered by
// a behavioural lab3 stage (x = parity, y = majority) with optional forcing/noise.
module tb_lab3_vec_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  start_s;
    logic [1:0]  a_s, b_s, c_s, busy_s, done_s, x_s, y_s;
    logic [2:0]  idx_s [2];
    logic [15:0] resp_s [2];
    logic [1:0]  st_s [2];

    int          mode [2];
    logic [1:0]  noisy, nx, ny;
    logic [15:0] exp_q [$];
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    lab3_vec_seq #(.PERIOD(10)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_s[0]), .x(x_s[0]), .y(y_s[0]),
        .a(a_s[0]), .b(b_s[0]), .c(c_s[0]), .busy(busy_s[0]), .done(done_s[0]),
        .vec_idx(idx_s[0]), .resp(resp_s[0]), .dbg_state(st_s[0])
    );

    lab3_vec_seq #(.PERIOD(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_s[1]), .x(x_s[1]), .y(y_s[1]),
        .a(a_s[1]), .b(b_s[1]), .c(c_s[1]), .busy(busy_s[1]), .done(done_s[1]),
        .vec_idx(idx_s[1]), .resp(resp_s[1]), .dbg_state(st_s[1])
    );

    // Stage model; mode 1 forces both bits high, mode 2 scrambles them outside capture cycles.
    always_comb begin
        x_s = 2'b00;
        y_s = 2'b00;
        for (int u = 0; u < 2; u++) begin
            x_s[u] = a_s[u] ^ b_s[u] ^ c_s[u];
            y_s[u] = (a_s[u] & b_s[u]) | (a_s[u] & c_s[u]) | (b_s[u] & c_s[u]);
            if (mode[u] == 1) begin
                x_s[u] = 1'b1;
                y_s[u] = 1'b1;
            end else if (mode[u] == 2 && noisy[u]) begin
                x_s[u] = nx[u];
                y_s[u] = ny[u];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [9:0] status(input int u);
        return {st_s[u], busy_s[u], done_s[u], a_s[u], b_s[u], c_s[u], idx_s[u]};
    endfunction

    // Caller is at a negedge; the next posedge is the start-accept edge S. Sample m is
    // taken at the negedge after edge S+m.
    task automatic run_unit(input int u, input int p, input int retrig, input bit keep_start,
                            input logic [15:0] exp_resp);
        logic [9:0]  e;
        logic [15:0] want;
        int          v;
        want = 16'h0000;
        start_s[u] = 1'b1;
        exp_q.push_back(exp_resp);
        for (int m = 0; m <= 8 * p + 1; m++) begin
            @(negedge clk);
            if (!keep_start) start_s[u] = (m == retrig);
            noisy[u] = (mode[u] == 2) && (m < 8 * p) && ((m % p) != (p - 1));
            nx[u] = 1'($urandom_range(0, 1));
            ny[u] = 1'($urandom_range(0, 1));
            if (m < 8 * p) begin
                v = m / p;
                e = {2'd1, 1'b1, 1'b0, 3'(v), 3'(v)};
            end else if (m == 8 * p) begin
                e = {2'd2, 1'b0, 1'b1, 3'd0, 3'd0};
            end else begin
                e = 10'd0;
            end
            check($sformatf("u%0d_p%0d_status_m%0d", u, p, m), 32'(status(u)), 32'(e));
            if (m == 0) check($sformatf("u%0d_resp_cleared", u), 32'(resp_s[u]), 32'h0);
            if (m == 8 * p) begin
                if (exp_q.size() == 0) begin
                    check("scoreboard_underflow", 32'(exp_q.size()), 32'd1);
                end else begin
                    want = exp_q.pop_front();
                    check($sformatf("u%0d_p%0d_resp", u, p), 32'(resp_s[u]), 32'(want));
                end
            end
            if (m == 8 * p + 1)
                check($sformatf("u%0d_resp_held_idle", u), 32'(resp_s[u]), 32'(want));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n   = 1'b0;
        start_s = 2'b00;
        mode[0] = 0;
        mode[1] = 0;
        noisy   = 2'b00;
        nx      = 2'b00;
        ny      = 2'b00;
        repeat (2) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            check($sformatf("u%0d_reset_status", u), 32'(status(u)), 32'h0);
            check($sformatf("u%0d_reset_resp", u), 32'(resp_s[u]), 32'h0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_after_release", 32'(status(0)), 32'h0);

        run_unit(0, 10, -1, 1'b0, 16'hE994);
        run_unit(1, 1, -1, 1'b0, 16'hE994);
        run_unit(0, 10, 32, 1'b0, 16'hE994);
        mode[0] = 1;
        run_unit(0, 10, -1, 1'b0, 16'hFFFF);
        mode[0] = 2;
        run_unit(0, 10, -1, 1'b0, 16'hE994);
        mode[0] = 0;

        run_unit(1, 1, -1, 1'b1, 16'hE994);
        run_unit(1, 1, -1, 1'b1, 16'hE994);
        run_unit(1, 1, -1, 1'b0, 16'hE994);

        // Abort during vector 5: reset lands mid-cycle, well clear of any clock edge.
        start_s[0] = 1'b1;
        for (int m = 0; m <= 53; m++) begin
            @(negedge clk);
            start_s[0] = 1'b0;
        end
        check("abort_in_vec5", 32'(idx_s[0]), 32'd5);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_status_u0", 32'(status(0)), 32'h0);
        check("async_rst_resp_u0", 32'(resp_s[0]), 32'h0);
        check("async_rst_resp_u1", 32'(resp_s[1]), 32'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("rst_hold_status_%0d", k), 32'(status(0)), 32'h0);
        end
        rst_n = 1'b1;
        run_unit(0, 10, -1, 1'b0, 16'hE994);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/lab3_vec_seq.md
LAB3_VEC_SEQ -- requirements
Module: lab3_vec_seq

Interface
REQ-001 Parameter: PERIOD, default 10, hold time per input vector in clock cycles; legal range 1..255.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  run request; sampled only in IDLE.
REQ-005 x  input  1  first response bit from the combinational lab3 stage.
REQ-006 y  input  1  second response bit from the combinational lab3 stage.
REQ-007 a  output  1  stimulus bit, MSB of current vector index.
REQ-008 b  output  1  stimulus bit, middle bit of current vector index.
REQ-009 c  output  1  stimulus bit, LSB of current vector index.
REQ-010 busy  output  1  high while vectors are being driven.
REQ-011 done  output  1  one-cycle pulse when all 8 responses are captured.
REQ-012 vec_idx  output  3  index of vector currently driven.
REQ-013 resp  output  16  captured responses; resp[2i+1:2i] = {y,x} for vector i.

Function
REQ-014 The FSM SHALL have states IDLE, HOLD, FINISH; all outputs registered.
REQ-015 IDLE: a,b,c = 0, vec_idx = 0, busy = 0, done = 0; resp holds its last value.
REQ-016 IDLE with start = 1 at an edge SHALL move to HOLD with vec_idx = 0, hold counter = 0, resp cleared to 0.
REQ-017 In HOLD, {a,b,c} SHALL equal vec_idx and busy SHALL be 1.
REQ-018 In HOLD, the hold counter (8 bits) SHALL increment each edge while below PERIOD-1.
REQ-019 At the edge where counter == PERIOD-1, the block SHALL capture {y,x} into resp[2*vec_idx+1:2*vec_idx], reset the counter to 0 and increment vec_idx.
REQ-020 Each vector SHALL therefore be driven for exactly PERIOD cycles, with responses sampled in the last cycle of its hold window.
REQ-021 At the capture edge for vec_idx = 7, the FSM SHALL go to FINISH; vec_idx SHALL wrap to 0 and a,b,c SHALL go to 0.
REQ-022 FINISH SHALL last one cycle with done = 1 and busy = 0, then go to IDLE unconditionally.
REQ-023 Latency: done SHALL be high in the cycle following edge S + 8*PERIOD, where S is the start-accept edge.
REQ-024 start in HOLD or FINISH SHALL be ignored; no restart or queuing. start held high SHALL retrigger only once back in IDLE.
REQ-025 PERIOD = 1 SHALL capture one vector per cycle, with the counter held at 0.
REQ-026 A PERIOD outside 1..255 SHALL be rejected at elaboration.

Reset
REQ-027 rst_n = 0 SHALL immediately, without waiting for clk, force IDLE, counter = 0, vec_idx = 0, a = b = c = 0, busy = 0, done = 0, resp = 0.
REQ-028 Reset asserted mid-run SHALL abort the run with no partial done pulse; the first edge after deassertion SHALL evaluate start from IDLE.

Verification
Bench model for all scenarios: x = a^b^c, y = majority(a,b,c).
REQ-029 Full run, PERIOD = 10 -> {a,b,c} steps 000..111, each held 10 cycles; done pulses once, 80 cycles after start accept; resp = 16'hE994.
REQ-030 Full run, PERIOD = 1 -> vec_idx advances every cycle; done 8 cycles after accept; resp = 16'hE994.
REQ-031 start pulsed again at vector 3 in HOLD -> ignored; sequence and done timing unchanged; resp = 16'hE994.
REQ-032 rst_n low asynchronously during vector 5 -> all outputs 0 before the next clk edge; no done; resp = 0.
REQ-033 start held high continuously -> back-to-back runs; each run shows a done pulse, one IDLE cycle, then busy again.
REQ-034 Model forced to x = y = 1 -> resp = 16'hFFFF; changing x,y outside each vector's last hold cycle -> resp unaffected.
